// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_W data bits, five parity modes,
// one or two stop bits, a one-entry holding register and line-break generation.
module uart_tx_cfg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_baud_tick,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [3:0]        i_cfg_data_bits,
    input  logic [2:0]        i_cfg_parity,
    input  logic              i_cfg_stop2,
    input  logic              i_break,
    output logic              o_tx_serial,
    output logic              o_tx_busy,
    output logic              o_tx_done
);
    localparam int unsigned     CntW    = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [3:0]      MinBits = 4'd5;
    localparam logic [3:0]      MaxBits = 4'(DATA_W);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              brk_q, brk_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              serial_q, serial_d;
    logic              busy_q;

    logic [3:0]        nbits_clamp;
    logic              par_calc;
    logic              par_en_load;
    logic              par_bit_load;
    logic              bit_end;
    logic              last_stop;
    logic              load;
    logic              done;
    logic [DATA_W-1:0] shifted;

    // Frame configuration derived from the inputs, captured only when a frame loads.
    always_comb begin
        nbits_clamp = i_cfg_data_bits;
        if (i_cfg_data_bits < MinBits) begin
            nbits_clamp = MinBits;
        end else if (i_cfg_data_bits > MaxBits) begin
            nbits_clamp = MaxBits;
        end
        par_calc = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i < int'(nbits_clamp)) par_calc = par_calc ^ hold_data_q[i];
        end
        par_en_load  = 1'b1;
        par_bit_load = 1'b0;
        case (i_cfg_parity)
            3'd1:    par_bit_load = par_calc;
            3'd2:    par_bit_load = ~par_calc;
            3'd3:    par_bit_load = 1'b1;
            3'd4:    par_bit_load = 1'b0;
            default: par_en_load  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        nbits_d      = nbits_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        brk_d        = brk_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        load         = 1'b0;
        done         = 1'b0;
        serial_d     = 1'b1;
        shifted      = '0;

        bit_end   = i_baud_tick && (cnt_q == CntLast);
        last_stop = (bit_idx_q == {3'b000, stop2_q & ~brk_q});

        if (i_baud_tick && (state_q inside {StStart, StData, StParity, StStop})) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                if (i_break) begin
                    state_d = StBreak;
                    cnt_d   = '0;
                end else if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d   = par_en_q ? StParity : StStop;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d   = StStop;
                    bit_idx_d = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (last_stop) begin
                        done  = ~brk_q;
                        brk_d = 1'b0;
                        if (i_break) begin
                            state_d = StBreak;
                        end else if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StBreak: begin
                // Trailing stop after a break is always a single bit period.
                if (!i_break) begin
                    state_d   = StStop;
                    brk_d     = 1'b1;
                    bit_idx_d = '0;
                    cnt_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d      = StStart;
            cnt_d        = '0;
            bit_idx_d    = '0;
            shift_d      = hold_data_q;
            nbits_d      = nbits_clamp;
            par_en_d     = par_en_load;
            par_bit_d    = par_bit_load;
            stop2_d      = i_cfg_stop2;
            brk_d        = 1'b0;
            hold_valid_d = 1'b0;
        end else if (i_tx_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = i_tx_data;
        end

        // Line value is registered from next-state so it lines up with the state register.
        shifted = shift_d >> bit_idx_d;
        case (state_d)
            StStart, StBreak: serial_d = 1'b0;
            StData:           serial_d = shifted[0];
            StParity:         serial_d = par_bit_d;
            default:          serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            nbits_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            brk_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            nbits_q      <= nbits_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            brk_q        <= brk_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            serial_q     <= serial_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    assign o_tx_ready  = ~hold_valid_q;
    assign o_tx_serial = serial_q;
    assign o_tx_busy   = busy_q;
    assign o_tx_done   = done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a frame model pushes expected line bits to a queue and a
// line monitor pops and compares them mid-bit; timing, break and reset are checked inline.
module tb_uart_tx_cfg;
    logic       clk;
    logic       i_rst;
    logic       i_baud_tick;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [3:0] cfg_bits;
    logic [2:0] cfg_par;
    logic       cfg_stop2;
    logic       i_break;
    logic       o_tx_serial;
    logic       o_tx_busy;
    logic       o_tx_done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic exp_bits[$];
    int   exp_len[$];
    int   starts_q[$];
    bit   in_frame = 1'b0;
    int   mon_left = 0;
    int   mon_phase = 0;

    uart_tx_cfg #(.DATA_W(8), .OVERSAMPLE(16)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_baud_tick     (i_baud_tick),
        .i_tx_data       (i_tx_data),
        .i_tx_valid      (i_tx_valid),
        .o_tx_ready      (o_tx_ready),
        .i_cfg_data_bits (cfg_bits),
        .i_cfg_parity    (cfg_par),
        .i_cfg_stop2     (cfg_stop2),
        .i_break         (i_break),
        .o_tx_serial     (o_tx_serial),
        .o_tx_busy       (o_tx_busy),
        .o_tx_done       (o_tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d, input logic [3:0] bits,
                                       input logic [2:0] par, input logic st2);
        int   nb;
        int   len;
        logic x;
        nb = (bits < 4'd5) ? 5 : ((bits > 4'd8) ? 8 : int'(bits));
        x  = 1'b0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_bits.push_back(d[i]);
            x = x ^ d[i];
        end
        len = 1 + nb;
        if (par >= 3'd1 && par <= 3'd4) begin
            exp_bits.push_back(par == 3'd1 ? x : (par == 3'd2 ? ~x : (par == 3'd3)));
            len++;
        end
        exp_bits.push_back(1'b1);
        len++;
        if (st2) begin
            exp_bits.push_back(1'b1);
            len++;
        end
        exp_len.push_back(len);
    endfunction

    // Line monitor: locks onto a start bit when a frame is expected, samples each bit mid-period.
    initial forever begin
        logic eb;
        @(negedge clk);
        if (o_tx_done === 1'b1) done_cnt++;
        if (i_rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && exp_len.size() > 0 && o_tx_serial === 1'b0) begin
                in_frame  = 1'b1;
                mon_left  = exp_len.pop_front();
                mon_phase = 0;
                starts_q.push_back(cyc);
            end
            if (in_frame) begin
                if (mon_phase == 8) begin
                    eb = exp_bits.pop_front();
                    chk("line_bit", 32'(o_tx_serial), 32'(eb));
                end
                mon_phase++;
                if (mon_phase == 16) begin
                    mon_phase = 0;
                    mon_left--;
                    if (mon_left == 0) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push);
        for (int j = 0; j < 400 && o_tx_ready !== 1'b1; j++) @(negedge clk);
        chk("send_ready", 32'(o_tx_ready), 32'd1);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        if (push) push_frame(d, cfg_bits, cfg_par, cfg_stop2);
        @(negedge clk);
        i_tx_valid = 1'b0;
        chk("ready_drop", 32'(o_tx_ready), 32'd0);
    endtask

    task automatic wait_start();
        int ok;
        ok = 0;
        for (int j = 0; j < 60; j++) begin
            if (o_tx_serial === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("start_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int ok;
        ok = 0;
        for (int j = 0; j < maxc; j++) begin
            @(negedge clk);
            if (exp_len.size() == 0 && !in_frame && o_tx_busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int k;
        int n;
        int d0;
        int n0;
        int gap;
        i_rst       = 1'b1;
        i_baud_tick = 1'b1;
        i_tx_data   = '0;
        i_tx_valid  = 1'b0;
        cfg_bits    = 4'd8;
        cfg_par     = 3'd0;
        cfg_stop2   = 1'b0;
        i_break     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(o_tx_serial), 32'd1);
        chk("rst_ready", 32'(o_tx_ready), 32'd1);
        chk("rst_busy", 32'(o_tx_busy), 32'd0);
        chk("rst_done", 32'(o_tx_done), 32'd0);
        i_rst = 1'b0;

        // 8N1 0xA5: two-cycle load latency, done on the 160th cycle of the frame
        send(8'hA5, 1'b1);
        chk("lat_idle", 32'(o_tx_serial), 32'd1);
        @(negedge clk);
        chk("lat_start", 32'(o_tx_serial), 32'd0);
        k = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (o_tx_done === 1'b1) begin
                k = j;
                break;
            end
        end
        chk("done_offset", 32'(k), 32'd159);
        chk("busy_at_done", 32'(o_tx_busy), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(o_tx_busy), 32'd0);
        chk("done_count_a5", 32'(done_cnt), 32'd1);
        wait_idle("idle_a5", 50);

        // 7-bit, two stop bits, each parity mode
        cfg_bits  = 4'd7;
        cfg_stop2 = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            cfg_par = 3'(p);
            send(8'h41, 1'b1);
            wait_idle("idle_parity", 400);
        end
        chk("done_count_par", 32'(done_cnt), 32'd5);

        // data-bit clamp, parity over clamped width only
        cfg_stop2 = 1'b0;
        cfg_bits  = 4'd3;
        cfg_par   = 3'd1;
        send(8'hF3, 1'b1);
        wait_idle("idle_clamp_lo", 400);
        cfg_bits = 4'd12;
        cfg_par  = 3'd0;
        send(8'h96, 1'b1);
        wait_idle("idle_clamp_hi", 400);

        // configuration change mid-frame must not affect the frame in flight
        cfg_bits = 4'd8;
        cfg_par  = 3'd1;
        send(8'h0B, 1'b1);
        wait_start();
        repeat (20) @(negedge clk);
        cfg_par   = 3'd2;
        cfg_bits  = 4'd5;
        cfg_stop2 = 1'b1;
        wait_idle("idle_cfg_change", 400);
        cfg_bits  = 4'd8;
        cfg_par   = 3'd0;
        cfg_stop2 = 1'b0;

        // back-to-back frames with zero idle between stop and start
        d0 = done_cnt;
        n0 = starts_q.size();
        send(8'h55, 1'b1);
        wait_start();
        repeat (40) @(negedge clk);
        send(8'hAA, 1'b1);
        repeat (100) @(negedge clk);
        chk("b2b_ready_held", 32'(o_tx_ready), 32'd0);
        wait_idle("idle_b2b", 500);
        gap = (starts_q.size() >= n0 + 2) ? (starts_q[n0 + 1] - starts_q[n0]) : -1;
        chk("b2b_start_gap", 32'(gap), 32'd160);
        chk("b2b_done_count", 32'(done_cnt), 32'(d0 + 2));

        // break from idle: 40 low, one 16-cycle stop, no done
        d0 = done_cnt;
        i_break = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_tx_serial === 1'b0) n++;
        end
        i_break = 1'b0;
        chk("break_low", 32'(n), 32'd40);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (o_tx_serial === 1'b1) n++;
        end
        chk("break_stop_high", 32'(n), 32'd16);
        chk("break_stop_busy", 32'(o_tx_busy), 32'd1);
        @(negedge clk);
        chk("break_idle", 32'(o_tx_busy), 32'd0);
        chk("break_no_done", 32'(done_cnt), 32'(d0));

        // break mid-frame waits for the frame; stop after break is one bit despite stop2
        cfg_stop2 = 1'b1;
        d0 = done_cnt;
        send(8'h5A, 1'b1);
        wait_start();
        repeat (30) @(negedge clk);
        i_break = 1'b1;
        k = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (o_tx_done === 1'b1) begin
                k = 1;
                break;
            end
        end
        chk("midbreak_done_seen", 32'(k), 32'd1);
        @(negedge clk);
        chk("midbreak_line_low", 32'(o_tx_serial), 32'd0);
        repeat (19) @(negedge clk);
        i_break = 1'b0;
        n = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (o_tx_busy !== 1'b1) break;
            n++;
        end
        chk("midbreak_stop_len", 32'(n), 32'd16);
        chk("midbreak_done_count", 32'(done_cnt), 32'(d0 + 1));
        chk("midbreak_queue_empty", 32'(exp_len.size()), 32'd0);
        cfg_stop2 = 1'b0;

        // reset mid-frame with a held frame: nothing further goes out
        d0 = done_cnt;
        send(8'h3C, 1'b0);
        wait_start();
        repeat (50) @(negedge clk);
        send(8'h99, 1'b0);
        i_rst = 1'b1;
        @(negedge clk);
        chk("midrst_serial", 32'(o_tx_serial), 32'd1);
        chk("midrst_ready", 32'(o_tx_ready), 32'd1);
        chk("midrst_busy", 32'(o_tx_busy), 32'd0);
        i_rst = 1'b0;
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_tx_serial !== 1'b1) n++;
        end
        chk("midrst_line_quiet", 32'(n), 32'd0);
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
